// File: rtl/core_pkg.sv
// Shared definitions for the core and its host-side front end.
// instr_t is the instruction type used by the queue and by the controller.
package core_pkg;
    localparam int INST_WIDTH      = 256;
    localparam int HOST_WORD_WIDTH = 32;

    typedef logic [INST_WIDTH-1:0] instr_t;
endpackage

// File: rtl/inst_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a synchronous flush.
// The head entry is always visible on rdata; count tracks the number of stored entries.
module inst_fifo #(
    parameter  int WIDTH = 256,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count_q != '0);

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (reset || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all state, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // NOTE: storage carries no reset; entries are only observable once count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/instr_queue.sv
// Host-side instruction queue: packs eight host words into one instruction and
// buffers complete instructions in an FWFT FIFO feeding the core's ready/valid port.
module instr_queue #(
    parameter  int DEPTH      = 16,
    parameter  int INST_WIDTH = core_pkg::INST_WIDTH,
    parameter  int WORD_WIDTH = core_pkg::HOST_WORD_WIDTH,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_wvalid,
    input  logic [WORD_WIDTH-1:0] host_wdata,
    output logic                  host_wready,
    input  logic                  flush,
    output logic [INST_WIDTH-1:0] instruction,
    output logic                  instruction_valid,
    input  logic                  instruction_ready,
    output logic [CW-1:0]         count,
    output logic [2:0]            word_idx
);
    localparam logic [2:0] LAST_IDX = 3'd7;

    logic [WORD_WIDTH-1:0] slots_q [7];
    logic [2:0]            word_idx_q, word_idx_d;
    logic [INST_WIDTH-1:0] push_data;
    logic                  full, accept, push, pop;
    logic [CW-1:0]         fifo_count;

    // Ready depends only on registered state and local controls, never on instruction_ready.
    assign host_wready = !reset && !flush && (word_idx_q != LAST_IDX || !full);
    assign accept      = host_wvalid && host_wready;
    assign push        = accept && (word_idx_q == LAST_IDX);

    assign instruction_valid = !reset && (fifo_count != '0);
    assign pop               = instruction_valid && instruction_ready;

    always_comb begin
        push_data = '0;
        for (int i = 0; i < 7; i++) begin
            push_data[i*WORD_WIDTH +: WORD_WIDTH] = slots_q[i];
        end
        push_data[INST_WIDTH-1 -: WORD_WIDTH] = host_wdata;
    end

    always_comb begin
        word_idx_d = word_idx_q;
        if (reset || flush) begin
            word_idx_d = '0;
        end else if (accept) begin
            word_idx_d = (word_idx_q == LAST_IDX) ? 3'd0 : word_idx_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        word_idx_q <= word_idx_d;
    end

    always_ff @(posedge clk) begin
        if (accept && (word_idx_q != LAST_IDX)) slots_q[word_idx_q] <= host_wdata;
    end

    inst_fifo #(
        .WIDTH (INST_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (instruction),
        .count (fifo_count),
        .full  (full)
    );

    assign count    = fifo_count;
    assign word_idx = word_idx_q;
endmodule

// File: tb/tb_instr_queue.sv
// Randomized bench for instr_queue: a queue-based reference model tracks the
// expected FIFO contents and assembler words; scenario tasks add targeted checks.
module tb_instr_queue;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            host_wvalid = 1'b0;
    logic [31:0]     host_wdata = '0;
    logic            host_wready;
    logic            flush = 1'b0;
    logic [255:0]    instruction;
    logic            instruction_valid;
    logic            instruction_ready = 1'b0;
    logic [CW-1:0]   count;
    logic [2:0]      word_idx;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queued instructions, words held by the assembler, and everything consumed.
    logic [255:0] mq[$];
    logic [31:0]  asm_q[$];
    logic [255:0] popped[$];

    instr_queue #(.DEPTH(DEPTH), .INST_WIDTH(256), .WORD_WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .host_wvalid       (host_wvalid),
        .host_wdata        (host_wdata),
        .host_wready       (host_wready),
        .flush             (flush),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready),
        .count             (count),
        .word_idx          (word_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: apply inputs, compare DUT against the model, advance the model at the edge.
    task automatic cycle(input logic wv, input logic [31:0] wd, input logic rdy,
                         input logic fl, input logic rst, output logic acc);
        logic         m_wr, m_val, m_pop;
        logic [255:0] ni;
        host_wvalid       = wv;
        host_wdata        = wd;
        instruction_ready = rdy;
        flush             = fl;
        reset             = rst;
        #1;
        m_wr  = !rst && !fl && (asm_q.size() != 7 || mq.size() != DEPTH);
        m_val = !rst && mq.size() != 0;
        n_vec++;
        if (host_wready !== m_wr) begin
            n_err++; $display("FAIL host_wready: got %b want %b", host_wready, m_wr);
        end
        n_vec++;
        if (instruction_valid !== m_val) begin
            n_err++; $display("FAIL instruction_valid: got %b want %b", instruction_valid, m_val);
        end
        n_vec++;
        if (count !== CW'(mq.size())) begin
            n_err++; $display("FAIL count: got %0d want %0d", count, mq.size());
        end
        n_vec++;
        if (word_idx !== 3'(asm_q.size())) begin
            n_err++; $display("FAIL word_idx: got %0d want %0d", word_idx, asm_q.size());
        end
        if (m_val) begin
            n_vec++;
            if (instruction !== mq[0]) begin
                n_err++; $display("FAIL head: got %h want %h", instruction, mq[0]);
            end
        end
        acc   = wv && m_wr;
        m_pop = m_val && rdy;
        @(posedge clk);
        if (m_pop) popped.push_back(mq.pop_front());
        if (rst || fl) begin
            mq.delete();
            asm_q.delete();
        end else if (acc) begin
            if (asm_q.size() == 7) begin
                for (int k = 0; k < 7; k++) ni[k*32 +: 32] = asm_q[k];
                ni[255:224] = wd;
                mq.push_back(ni);
                asm_q.delete();
            end else begin
                asm_q.push_back(wd);
            end
        end
        #1;
    endtask

    task automatic send_word(input logic [31:0] wd, input logic rdy);
        logic acc;
        int   tries = 0;
        acc = 1'b0;
        while (!acc && tries < 100) begin
            cycle(1'b1, wd, rdy, 1'b0, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            n_vec++; n_err++; $display("FAIL send_word: word %h never accepted", wd);
        end
    endtask

    task automatic drain();
        logic acc;
        int   tries = 0;
        while (mq.size() != 0 && tries < 100) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);
            tries++;
        end
        n_vec++;
        if (count !== '0) begin
            n_err++; $display("FAIL drain: count %0d want 0", count);
        end
    endtask

    task automatic test_reset();
        logic acc;
        cycle(1'b1, 32'hdead_beef, 1'b1, 1'b0, 1'b1, acc);
        cycle(1'b1, 32'hdead_beef, 1'b1, 1'b0, 1'b1, acc);
        n_vec++;
        if (host_wready !== 1'b0 || instruction_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: wready %b valid %b want 0 0", host_wready, instruction_valid);
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        n_vec++;
        if (count !== '0 || word_idx !== 3'd0 || host_wready !== 1'b1) begin
            n_err++; $display("FAIL reset_state: count %0d idx %0d wready %b want 0 0 1", count, word_idx, host_wready);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 8; i++) send_word(32'(i), 1'b0);
        n_vec++;
        if (instruction_valid !== 1'b1 || count !== CW'(1)) begin
            n_err++; $display("FAIL single_valid: valid %b count %0d want 1 1", instruction_valid, count);
        end
        n_vec++;
        if (instruction[31:0] !== 32'd0 || instruction[255:224] !== 32'd7) begin
            n_err++; $display("FAIL single_data: w0 %h w7 %h want 0 7", instruction[31:0], instruction[255:224]);
        end
        drain();
    endtask

    task automatic test_fill();
        logic acc;
        int   tries = 0;
        while (!(mq.size() == DEPTH && asm_q.size() == 7) && tries < 300) begin
            cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, acc);
            tries++;
        end
        n_vec++;
        if (count !== CW'(DEPTH) || word_idx !== 3'd7 || host_wready !== 1'b0) begin
            n_err++; $display("FAIL fill_full: count %0d idx %0d wready %b want 16 7 0", count, word_idx, host_wready);
        end
        cycle(1'b1, 32'h1717_0007, 1'b1, 1'b0, 1'b0, acc);
        n_vec++;
        if (acc !== 1'b0 || host_wready !== 1'b1) begin
            n_err++; $display("FAIL fill_pop: acc %b wready-after %b want 0 1", acc, host_wready);
        end
        cycle(1'b1, 32'h1717_0007, 1'b0, 1'b0, 1'b0, acc);
        n_vec++;
        if (count !== CW'(DEPTH) || word_idx !== 3'd0) begin
            n_err++; $display("FAIL fill_refill: count %0d idx %0d want 16 0", count, word_idx);
        end
        drain();
    endtask

    task automatic test_simul_push_pop();
        logic acc;
        for (int i = 0; i < 8; i++) send_word(32'ha000_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 7; i++) send_word(32'hb000_0000 + 32'(i), 1'b0);
        cycle(1'b1, 32'hb000_0007, 1'b1, 1'b0, 1'b0, acc);
        n_vec++;
        if (count !== CW'(1) || instruction_valid !== 1'b1) begin
            n_err++; $display("FAIL simul_count: count %0d valid %b want 1 1", count, instruction_valid);
        end
        n_vec++;
        if (instruction[31:0] !== 32'hb000_0000 || instruction[255:224] !== 32'hb000_0007) begin
            n_err++; $display("FAIL simul_head: w0 %h w7 %h want b0000000 b0000007", instruction[31:0], instruction[255:224]);
        end
        drain();
    endtask

    task automatic test_wrap();
        logic acc;
        logic wv;
        int   widx = 0;
        int   base = popped.size();
        int   tries = 0;
        logic [31:0] wd;
        while (!(widx == 320 && mq.size() == 0) && tries < 3000) begin
            wv = (widx < 320) && ($urandom_range(3) != 0);
            wd = (widx % 8 == 0) ? 32'(widx / 8) : $urandom;
            cycle(wv, wd, $urandom_range(3) != 0, 1'b0, 1'b0, acc);
            if (acc) widx++;
            tries++;
        end
        n_vec++;
        if (popped.size() - base != 40) begin
            n_err++; $display("FAIL wrap_total: got %0d instructions want 40", popped.size() - base);
        end else begin
            for (int i = 0; i < 40; i++) begin
                n_vec++;
                if (popped[base+i][31:0] !== 32'(i)) begin
                    n_err++; $display("FAIL wrap_tag: got %0d want %0d", popped[base+i][31:0], i);
                end
            end
        end
    endtask

    task automatic test_flush();
        logic acc;
        for (int i = 0; i < 28; i++) send_word($urandom, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        n_vec++;
        if (count !== '0 || word_idx !== 3'd0 || instruction_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_state: count %0d idx %0d valid %b want 0 0 0", count, word_idx, instruction_valid);
        end
        for (int i = 0; i < 8; i++) send_word(32'hc000_0000 + 32'(i), 1'b0);
        n_vec++;
        if (count !== CW'(1) || instruction[31:0] !== 32'hc000_0000 || instruction[255:224] !== 32'hc000_0007) begin
            n_err++; $display("FAIL flush_after: count %0d w0 %h w7 %h want 1 c0000000 c0000007",
                              count, instruction[31:0], instruction[255:224]);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic acc;
        for (int i = 0; i < 43; i++) send_word($urandom, 1'b0);
        reset = 1'b1;
        #1;
        n_vec++;
        if (host_wready !== 1'b0 || instruction_valid !== 1'b0 || count !== CW'(5)) begin
            n_err++; $display("FAIL reset_mid_during: wready %b valid %b count %0d want 0 0 5",
                              host_wready, instruction_valid, count);
        end
        cycle(1'b1, 32'h1, 1'b1, 1'b0, 1'b1, acc);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, acc);
        n_vec++;
        if (count !== '0 || host_wready !== 1'b1 || word_idx !== 3'd0) begin
            n_err++; $display("FAIL reset_mid_after: count %0d wready %b idx %0d want 0 1 0", count, host_wready, word_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_simul_push_pop();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
